frame_write_ctrl: RTL and testbench
===================================

FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, bits per row data word.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, frames per column.
REQ-003 SHALL have parameter NumberOfRows, default 16, data words per frame.
REQ-004 SHALL have parameter NumberOfCols, default 4, columns addressed.
REQ-005 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_valid  input  1  config word valid.
REQ-008 SHALL have port s_ready  output  1  config word accepted when s_valid&&s_ready.
REQ-009 SHALL have port s_data  input  32  config word (header, data or checksum).
REQ-010 SHALL have port FrameData  output  NumberOfRows*FrameBitsPerRow  row data; row r at [r*FrameBitsPerRow +: FrameBitsPerRow].
REQ-011 SHALL have port FrameStrobe  output  NumberOfCols*MaxFramesPerCol  strobe; column c at [c*MaxFramesPerCol +: MaxFramesPerCol].
REQ-012 SHALL have port done  output  1  one-cycle pulse per committed frame.
REQ-013 SHALL have port err  output  1  sticky error flag.

Function
REQ-014 SHALL decode header fields col=s_data[20:16] and frame=s_data[4:0]; all other header bits are ignored.
REQ-015 SHALL implement FSM IDLE -> DATA -> (CHECK) -> STROBE -> GAP -> IDLE.
REQ-016 SHALL, in IDLE, accept one header word; if col>=NumberOfCols or frame>=MaxFramesPerCol, set err and stay in IDLE; otherwise latch col/frame and enter DATA.
REQ-017 SHALL, in DATA, write accepted word k into row k of FrameData, rows 0..NumberOfRows-1 in order, using a row counter that clears on DATA entry.
REQ-018 SHALL leave DATA after row NumberOfRows-1 is accepted.
REQ-019 SHALL drive s_ready=1 only in IDLE, DATA and CHECK; s_valid with s_ready low SHALL be held, never dropped.
REQ-020 SHALL, in STROBE, drive exactly one FrameStrobe bit, col*MaxFramesPerCol+frame, high for exactly one cycle; all other FrameStrobe bits stay 0.
REQ-021 SHALL keep FrameData stable from STROBE entry until the next DATA write.
REQ-022 SHALL, in GAP, hold all FrameStrobe bits low for one cycle, pulse done for that cycle, then return to IDLE.
REQ-023 SHALL give a minimum header-to-done latency of NumberOfRows+3 cycles (header, rows, STROBE, GAP) with s_valid held high.
REQ-024 SHALL clear err only by reset; err SHALL NOT block later frames.

Reset
REQ-025 SHALL, on RST, force state IDLE, row counter 0, FrameData 0, FrameStrobe 0, done 0, err 0 and s_ready 0 while RST is high.
REQ-026 SHALL, on reset mid-frame, drop the partial frame, issue no strobe, and accept a fresh header in the first cycle after RST falls.

Configuration
REQ-027 SHALL, with FRAME_WRITE_CHECK_EN defined, enter CHECK after the last data word.
REQ-028 SHALL, with FRAME_WRITE_CHECK_EN defined, accept one checksum word in CHECK that must equal the XOR of all NumberOfRows data words.
REQ-029 SHALL, with FRAME_WRITE_CHECK_EN defined, go STROBE on checksum match; on mismatch, set err, issue no strobe and no done, and return to IDLE.
REQ-030 SHALL, without FRAME_WRITE_CHECK_EN, omit CHECK and the checksum logic and go directly DATA -> STROBE.

Structure
REQ-031 SHALL place the FSM state enum, header field positions/widths and the checksum word definition in shared package frame_cfg_pkg.
REQ-032 SHALL contain one sub-module, frame_strobe_decode: registered one-hot decode of {col, frame, enable} onto FrameStrobe.

Verification
REQ-033 SHALL verify: header col=2,frame=5, rows 0x00000000..0x0000000F back-to-back -> FrameData row r=r, FrameStrobe bit 45 high one cycle, done in the GAP cycle, err=0.
REQ-034 SHALL verify: header col=4 (>=NumberOfCols) -> err=1, FSM stays IDLE, next valid header col=0,frame=0 commits bit 0.
REQ-035 SHALL verify: s_valid toggled randomly during DATA -> row order preserved, FrameData identical to the back-to-back case.
REQ-036 SHALL verify: RST pulsed after 7 of 16 rows -> no strobe, FrameData=0, next full frame commits normally.
REQ-037 SHALL verify (FRAME_WRITE_CHECK_EN): correct XOR checksum -> strobe issued; checksum^1 -> err=1, no strobe, no done.
REQ-038 SHALL verify: two frames back-to-back -> each strobe one cycle, at least one strobe-low GAP cycle between them, s_ready=0 during STROBE/GAP.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared configuration for the frame write controller: FSM encodings, header field layout
// and the checksum word definition (checksum used only with FRAME_WRITE_CHECK_EN).
package frame_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StData   = 3'd1;
  localparam state_t StCheck  = 3'd2;
  localparam state_t StStrobe = 3'd3;
  localparam state_t StGap    = 3'd4;

  localparam int unsigned WordWidth     = 32;
  localparam int unsigned HdrColLsb     = 16;
  localparam int unsigned HdrColWidth   = 5;
  localparam int unsigned HdrFrameLsb   = 0;
  localparam int unsigned HdrFrameWidth = 5;

  typedef logic [WordWidth-1:0]     word_t;
  typedef logic [HdrColWidth-1:0]   col_t;
  typedef logic [HdrFrameWidth-1:0] frame_t;

  // Checksum is the running XOR of every data word in a frame.
  typedef logic [WordWidth-1:0] csum_t;

  function automatic col_t hdr_col(input word_t w);
    return w[HdrColLsb +: HdrColWidth];
  endfunction

  function automatic frame_t hdr_frame(input word_t w);
    return w[HdrFrameLsb +: HdrFrameWidth];
  endfunction

  function automatic csum_t csum_update(input csum_t acc, input word_t w);
    return acc ^ w;
  endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// Registered one-hot decode of {col, frame, enable} onto the flat frame strobe vector.
module frame_strobe_decode
  import frame_cfg_pkg::*;
#(
  parameter int unsigned NumCols      = 4,
  parameter int unsigned FramesPerCol = 20
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  col_t                              col,
  input  frame_t                            frame,
  input  logic                              enable,
  output logic [NumCols*FramesPerCol-1:0]   strobe
);

  localparam int unsigned Total = NumCols * FramesPerCol;

  logic [31:0]      sel;
  logic [Total-1:0] strobe_d;

  assign sel = 32'(col) * FramesPerCol + 32'(frame);

  for (genvar i = 0; i < Total; i++) begin : g_bit
    assign strobe_d[i] = enable && (sel == i);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      strobe <= '0;
    end else begin
      strobe <= strobe_d;
    end
  end

endmodule

// File: rtl/frame_write_ctrl.sv
// Frame write controller: header + row words -> FrameData, then a one-cycle frame strobe.
// Define FRAME_WRITE_CHECK_EN to require an XOR checksum word after the data rows.
module frame_write_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumberOfRows    = 16,
  parameter int unsigned NumberOfCols    = 4
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [31:0]                             s_data,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    done,
  output logic                                    err
);

  localparam int unsigned RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

  state_t          state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  col_t            col_q, col_d;
  frame_t          frame_q, frame_d;
  logic            err_q, err_d;
  logic            accept, hdr_ok, row_we, strobe_en;

  logic [FrameBitsPerRow-1:0] row_word;
  logic [FrameBitsPerRow-1:0] rows_q [NumberOfRows];

`ifdef FRAME_WRITE_CHECK_EN
  csum_t csum_q, csum_d;
`endif

  // Ready is forced low while reset is held so no word is consumed during reset.
  assign s_ready = !RST && ((state_q == StIdle) || (state_q == StData) ||
                            (state_q == StCheck));
  assign accept  = s_valid && s_ready;
  assign hdr_ok  = (32'(hdr_col(s_data)) < NumberOfCols) &&
                   (32'(hdr_frame(s_data)) < MaxFramesPerCol);
  assign row_word = FrameBitsPerRow'(s_data);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    frame_d = frame_q;
    err_d   = err_q;
    row_we  = 1'b0;
`ifdef FRAME_WRITE_CHECK_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_ok) begin
            col_d   = hdr_col(s_data);
            frame_d = hdr_frame(s_data);
            row_d   = '0;
            state_d = StData;
`ifdef FRAME_WRITE_CHECK_EN
            csum_d  = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (accept) begin
          row_we = 1'b1;
`ifdef FRAME_WRITE_CHECK_EN
          csum_d = csum_update(csum_q, s_data);
`endif
          if (row_q == LastRow) begin
`ifdef FRAME_WRITE_CHECK_EN
            state_d = StCheck;
`else
            state_d = StStrobe;
`endif
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
`ifdef FRAME_WRITE_CHECK_EN
      StCheck: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = StStrobe;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif
      StStrobe: state_d = StGap;
      StGap:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

`ifdef FRAME_WRITE_CHECK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned r = 0; r < NumberOfRows; r++) begin
        rows_q[r] <= '0;
      end
    end else if (row_we) begin
      rows_q[row_q] <= row_word;
    end
  end

  for (genvar g = 0; g < NumberOfRows; g++) begin : g_row
    assign FrameData[g*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[g];
  end

  // Decoder is registered, so it is armed on the cycle the FSM moves into STROBE.
  assign strobe_en = (state_d == StStrobe);

  frame_strobe_decode #(
    .NumCols      (NumberOfCols),
    .FramesPerCol (MaxFramesPerCol)
  ) u_strobe_decode (
    .CLK    (CLK),
    .RST    (RST),
    .col    (col_q),
    .frame  (frame_q),
    .enable (strobe_en),
    .strobe (FrameStrobe)
  );

  assign done = (state_q == StGap);
  assign err  = err_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed self-checking bench for frame_write_ctrl; FRAME_WRITE_CHECK_EN adds checksum cases.
`timescale 1ns/1ps
module tb_frame_write_ctrl;

  localparam int unsigned W    = 32;
  localparam int unsigned FPC  = 20;
  localparam int unsigned ROWS = 16;
  localparam int unsigned COLS = 4;
  localparam int unsigned DW   = ROWS * W;
  localparam int unsigned SW   = COLS * FPC;
`ifdef FRAME_WRITE_CHECK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  frame_write_ctrl #(
    .FrameBitsPerRow (W),
    .MaxFramesPerCol (FPC),
    .NumberOfRows    (ROWS),
    .NumberOfCols    (COLS)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .done        (done),
    .err         (err)
  );

  // Passive observer: counts strobe/done events for the scenario tasks to compare against.
  int unsigned   mon_strobe = 0, mon_done = 0, mon_gap_done = 0, mon_ready_bad = 0;
  int unsigned   mon_multi = 0;
  logic [SW-1:0] strobe_log[$];
  bit            prev_strobe = 1'b0;

  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      mon_strobe++;
      strobe_log.push_back(FrameStrobe);
      if ($countones(FrameStrobe) != 1) mon_multi++;
    end
    if (done) begin
      mon_done++;
      if (prev_strobe && FrameStrobe == '0) mon_gap_done++;
    end
    if ((FrameStrobe != '0 || done) && s_ready) mon_ready_bad++;
    prev_strobe = |FrameStrobe;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_frame(input logic [31:0] base);
    logic [DW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*W +: W] = base + 32'(r);
    return v;
  endfunction

  function automatic logic [SW-1:0] one_hot(input int col, input int frm);
    logic [SW-1:0] v;
    v = '0;
    v[col*FPC + frm] = 1'b1;
    return v;
  endfunction

  task automatic send_word(input logic [31:0] w, input bit throttle, output bit ok,
                           output int tries);
    if (throttle) begin
      int idle;
      idle = $urandom_range(0, 3);
      s_valid = 1'b0;
      repeat (idle) tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    ok      = 1'b0;
    tries   = 0;
    while (!ok && tries < 64) begin
      ok = s_ready;
      tries++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Header carries junk in the ignored bits; returns in the cycle after the last accept.
  task automatic send_frame(input logic [4:0] col, input logic [4:0] frm,
                            input logic [31:0] base, input bit throttle, input int nrows,
                            input logic [31:0] csum_flip, output int tries,
                            output int timeouts);
    logic [31:0] csum;
    bit          ok;
    int          t;
    tries    = 0;
    timeouts = 0;
    csum     = csum_flip;
    send_word({11'h2A5, col, 11'h355, frm}, 1'b0, ok, t);
    tries += t;
    if (!ok) timeouts++;
    for (int r = 0; r < nrows; r++) begin
      send_word(base + 32'(r), throttle, ok, t);
      tries += t;
      if (!ok) timeouts++;
      csum ^= base + 32'(r);
    end
`ifdef FRAME_WRITE_CHECK_EN
    if (nrows == ROWS) begin
      send_word(csum, throttle, ok, t);
      tries += t;
      if (!ok) timeouts++;
    end
`endif
  endtask

  task automatic test_reset;
    RST = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", s_ready); end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL reset_strobe got %h want 0", FrameStrobe); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (FrameData !== '0) begin errors++; $display("FAIL reset_data got %h want 0", FrameData); end
    RST = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", s_ready); end
  endtask

  task automatic test_basic;
    int tries, to;
    int unsigned s0, d0;
    s0 = mon_strobe; d0 = mon_done;
    send_frame(5'd2, 5'd5, 32'h0, 1'b0, ROWS, 32'h0, tries, to);
    checks++; if (to != 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", to); end
    checks++; if (tries != ROWS + 1 + EXTRA) begin errors++; $display("FAIL basic_accept_cycles got %0d want %0d", tries, ROWS + 1 + EXTRA); end
    checks++; if (FrameStrobe !== one_hot(45 / FPC, 45 % FPC)) begin errors++; $display("FAIL basic_strobe got %h want bit 45", FrameStrobe); end
    checks++; if (done !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL basic_strobe_cycle done=%b ready=%b want 0 0", done, s_ready); end
    checks++; if (FrameData !== exp_frame(32'h0)) begin errors++; $display("FAIL basic_data got %h want %h", FrameData, exp_frame(32'h0)); end
    tick();
    checks++; if (FrameStrobe !== '0 || done !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL basic_gap strobe=%h done=%b ready=%b want 0 1 0", FrameStrobe, done, s_ready); end
    tick();
    checks++; if (done !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL basic_idle done=%b ready=%b err=%b want 0 1 0", done, s_ready, err); end
    checks++; if (FrameData !== exp_frame(32'h0)) begin errors++; $display("FAIL basic_data_hold got %h want %h", FrameData, exp_frame(32'h0)); end
    checks++; if (mon_strobe - s0 != 1 || mon_done - d0 != 1) begin errors++; $display("FAIL basic_counts strobes=%0d dones=%0d want 1 1", mon_strobe - s0, mon_done - d0); end
  endtask

  task automatic test_bad_header;
    bit ok;
    int t, tries, to;
    int unsigned s0, d0;
    s0 = mon_strobe;
    send_word({11'h0, 5'd4, 11'h0, 5'd0}, 1'b0, ok, t);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL badcol_err got ok=%b err=%b want 1 1", ok, err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL badcol_idle got ready=%b want 1", s_ready); end
    send_word({11'h0, 5'd0, 11'h0, 5'd20}, 1'b0, ok, t);
    checks++; if (!ok || err !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL badframe got ok=%b err=%b ready=%b want 1 1 1", ok, err, s_ready); end
    repeat (2) tick();
    checks++; if (mon_strobe != s0) begin errors++; $display("FAIL bad_no_strobe got %0d strobes want 0", mon_strobe - s0); end
    d0 = mon_done;
    send_frame(5'd0, 5'd0, 32'h1000, 1'b0, ROWS, 32'h0, tries, to);
    checks++; if (FrameStrobe !== one_hot(0, 0) || to != 0) begin errors++; $display("FAIL bad_then_good strobe=%h timeouts=%0d want bit 0 and 0", FrameStrobe, to); end
    repeat (2) tick();
    checks++; if (mon_done - d0 != 1 || err !== 1'b1) begin errors++; $display("FAIL bad_sticky dones=%0d err=%b want 1 1", mon_done - d0, err); end
  endtask

  task automatic test_throttle;
    int tries, to, l0;
    l0 = strobe_log.size();
    send_frame(5'd1, 5'd7, 32'h0, 1'b1, ROWS, 32'h0, tries, to);
    repeat (2) tick();
    checks++; if (to != 0) begin errors++; $display("FAIL thr_timeout got %0d want 0", to); end
    checks++; if (FrameData !== exp_frame(32'h0)) begin errors++; $display("FAIL thr_data got %h want %h", FrameData, exp_frame(32'h0)); end
    checks++; if (strobe_log.size() - l0 != 1) begin errors++; $display("FAIL thr_strobe_count got %0d want 1", strobe_log.size() - l0); end
    else begin
      checks++; if (strobe_log[l0] !== one_hot(1, 7)) begin errors++; $display("FAIL thr_strobe got %h want %h", strobe_log[l0], one_hot(1, 7)); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int tries, to;
    int unsigned s0, d0;
    s0 = mon_strobe;
    send_frame(5'd1, 5'd3, 32'hCAFE_0000, 1'b0, 7, 32'h0, tries, to);
    RST = 1'b1;
    #1;
    checks++; if (FrameData !== '0 || s_ready !== 1'b0) begin errors++; $display("FAIL rst_async data=%h ready=%b want 0 0", FrameData, s_ready); end
    repeat (2) tick();
    checks++; if (err !== 1'b0 || FrameStrobe !== '0) begin errors++; $display("FAIL rst_clear err=%b strobe=%h want 0 0", err, FrameStrobe); end
    RST = 1'b0;
    #1;
    checks++; if (mon_strobe != s0) begin errors++; $display("FAIL rst_no_strobe got %0d want 0", mon_strobe - s0); end
    d0 = mon_done;
    send_frame(5'd3, 5'd19, 32'h5555_0000, 1'b0, ROWS, 32'h0, tries, to);
    checks++; if (tries != ROWS + 1 + EXTRA) begin errors++; $display("FAIL rst_fresh_cycles got %0d want %0d", tries, ROWS + 1 + EXTRA); end
    checks++; if (FrameStrobe !== one_hot(3, 19)) begin errors++; $display("FAIL rst_top_bit got %h want %h", FrameStrobe, one_hot(3, 19)); end
    repeat (2) tick();
    checks++; if (FrameData !== exp_frame(32'h5555_0000) || mon_done - d0 != 1) begin errors++; $display("FAIL rst_next_frame data=%h dones=%0d want %h 1", FrameData, mon_done - d0, exp_frame(32'h5555_0000)); end
  endtask

  task automatic test_back_to_back;
    int tries_a, tries_b, to_a, to_b, l0;
    int unsigned s0, d0, g0, r0, m0;
    l0 = strobe_log.size();
    s0 = mon_strobe; d0 = mon_done; g0 = mon_gap_done; r0 = mon_ready_bad; m0 = mon_multi;
    send_frame(5'd1, 5'd0, 32'h1111_0000, 1'b0, ROWS, 32'h0, tries_a, to_a);
    send_frame(5'd0, 5'd19, 32'h2222_0000, 1'b0, ROWS, 32'h0, tries_b, to_b);
    repeat (2) tick();
    checks++; if (tries_b != ROWS + 3 + EXTRA || to_a + to_b != 0) begin errors++; $display("FAIL b2b_hdr_wait got %0d want %0d", tries_b, ROWS + 3 + EXTRA); end
    checks++; if (mon_strobe - s0 != 2 || strobe_log.size() - l0 != 2) begin errors++; $display("FAIL b2b_strobe_cycles got %0d want 2", mon_strobe - s0); end
    else begin
      checks++; if (strobe_log[l0] !== one_hot(1, 0) || strobe_log[l0+1] !== one_hot(0, 19)) begin errors++; $display("FAIL b2b_strobes got %h %h want %h %h", strobe_log[l0], strobe_log[l0+1], one_hot(1, 0), one_hot(0, 19)); end
    end
    checks++; if (mon_done - d0 != 2 || mon_gap_done - g0 != 2) begin errors++; $display("FAIL b2b_gap dones=%0d gapdones=%0d want 2 2", mon_done - d0, mon_gap_done - g0); end
    checks++; if (mon_ready_bad != r0 || mon_multi != m0) begin errors++; $display("FAIL b2b_ready_low ready_viol=%0d multi=%0d want 0 0", mon_ready_bad - r0, mon_multi - m0); end
    checks++; if (FrameData !== exp_frame(32'h2222_0000)) begin errors++; $display("FAIL b2b_data got %h want %h", FrameData, exp_frame(32'h2222_0000)); end
  endtask

`ifdef FRAME_WRITE_CHECK_EN
  task automatic test_checksum;
    int tries, to;
    int unsigned s0, d0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_pre_err got %b want 0", err); end
    send_frame(5'd2, 5'd0, 32'h0F0F_0000, 1'b0, ROWS, 32'h0, tries, to);
    checks++; if (FrameStrobe !== one_hot(2, 0)) begin errors++; $display("FAIL csum_good got %h want %h", FrameStrobe, one_hot(2, 0)); end
    repeat (2) tick();
    s0 = mon_strobe; d0 = mon_done;
    send_frame(5'd2, 5'd1, 32'h0F0F_0000, 1'b0, ROWS, 32'h1, tries, to);
    checks++; if (err !== 1'b1 || FrameStrobe !== '0 || s_ready !== 1'b1) begin errors++; $display("FAIL csum_bad err=%b strobe=%h ready=%b want 1 0 1", err, FrameStrobe, s_ready); end
    repeat (3) tick();
    checks++; if (mon_strobe != s0 || mon_done != d0) begin errors++; $display("FAIL csum_bad_quiet strobes=%0d dones=%0d want 0 0", mon_strobe - s0, mon_done - d0); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_throttle();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef FRAME_WRITE_CHECK_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
